// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer with write-back bypass, branch/JALR self-squash and in-order commit.
// Define ROB_DUAL_COMMIT_EN to let a committing REG head retire a REG/STORE successor in the same cycle.
module rob_param #(
    parameter int  XLEN     = 32,
    parameter int  DEPTH    = 16,
    parameter int  NUM_WB   = 3,
    parameter int  LSB_ID_W = 3,
    parameter int  REG_W    = 5,
    localparam int ID_W     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     dis_valid,
    output logic                     dis_ready,
    output logic [ID_W-1:0]          dis_id,
    input  logic [1:0]               dis_kind,
    input  logic [REG_W-1:0]         dis_rd,
    input  logic                     dis_done,
    input  logic [XLEN-1:0]          dis_val,
    input  logic [XLEN-1:0]          dis_pc,
    input  logic [XLEN-1:0]          dis_target,
    input  logic [XLEN-1:0]          dis_fallthru,
    input  logic                     dis_pred,
    input  logic [LSB_ID_W-1:0]      dis_lsb_id,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*ID_W-1:0]   wb_id,
    input  logic [NUM_WB*XLEN-1:0]   wb_val,
    input  logic [ID_W-1:0]          q1_id,
    input  logic [ID_W-1:0]          q2_id,
    output logic                     q1_ready,
    output logic                     q2_ready,
    output logic [XLEN-1:0]          q1_val,
    output logic [XLEN-1:0]          q2_val,
    output logic                     rf_we0,
    output logic [REG_W-1:0]         rf_rd0,
    output logic [XLEN-1:0]          rf_val0,
    output logic                     rf_we1,
    output logic [REG_W-1:0]         rf_rd1,
    output logic [XLEN-1:0]          rf_val1,
    output logic                     st_commit,
    output logic [LSB_ID_W-1:0]      st_lsb_id,
    output logic                     bp_valid,
    output logic [XLEN-1:0]          bp_pc,
    output logic                     bp_taken,
    output logic                     bp_correct,
    output logic                     redirect,
    output logic [XLEN-1:0]          redirect_pc,
    output logic [ID_W:0]            count
);
    localparam logic [1:0] K_REG = 2'd0, K_ST = 2'd1, K_BR = 2'd2, K_JALR = 2'd3;
    logic [DEPTH-1:0]    valid, ready, pred;
    logic [1:0]          kind     [DEPTH];
    logic [REG_W-1:0]    rd       [DEPTH];
    logic [XLEN-1:0]     val      [DEPTH];
    logic [XLEN-1:0]     target   [DEPTH];
    logic [XLEN-1:0]     fallthru [DEPTH];
    logic [XLEN-1:0]     pc       [DEPTH];
    logic [LSB_ID_W-1:0] lsb_id   [DEPTH];
    logic [ID_W-1:0]     head, tail, h1;
    logic                c0, c1, w0, taken, redir, dis_fire, q1_hit, q2_hit;
    logic [XLEN-1:0]     rpc, q1_wv, q2_wv;

    assign h1        = head + ID_W'(1);
    assign dis_ready = count != (ID_W+1)'(DEPTH);
    assign dis_id    = tail;
    assign dis_fire  = dis_valid && dis_ready;
    assign c0        = valid[head] && ready[head];
    assign w0        = (kind[head] == K_REG || kind[head] == K_JALR) && rd[head] != '0;
    assign taken     = val[head][0];
    assign redir     = c0 && (kind[head] == K_JALR || (kind[head] == K_BR && pred[head] != taken));
    assign rpc       = (kind[head] == K_JALR || taken) ? target[head] : fallthru[head];
`ifdef ROB_DUAL_COMMIT_EN
    assign c1        = c0 && kind[head] == K_REG && valid[h1] && ready[h1] && !kind[h1][1];
`else
    assign c1        = 1'b0;
`endif
    assign q1_ready  = valid[q1_id] && (ready[q1_id] || q1_hit);
    assign q2_ready  = valid[q2_id] && (ready[q2_id] || q2_hit);
    // JALR results are branch targets, so operand consumers keep seeing the stored link value
    assign q1_val    = (q1_hit && kind[q1_id] != K_JALR) ? q1_wv : val[q1_id];
    assign q2_val    = (q2_hit && kind[q2_id] != K_JALR) ? q2_wv : val[q2_id];

    // Same-cycle write-back hits for operand lookups; the highest port wins as in the array write
    always_comb begin
        q1_hit = 1'b0;
        q2_hit = 1'b0;
        q1_wv  = '0;
        q2_wv  = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && wb_id[k*ID_W +: ID_W] == q1_id) begin
                q1_hit = 1'b1;
                q1_wv  = wb_val[k*XLEN +: XLEN];
            end
            if (wb_valid[k] && wb_id[k*ID_W +: ID_W] == q2_id) begin
                q2_hit = 1'b1;
                q2_wv  = wb_val[k*XLEN +: XLEN];
            end
        end
    end

    // Dispatch, write-back, commit and squash; everything holds while rdy is low
    always_ff @(posedge clk) begin
        if (rst || rdy) begin
            rf_we0      <= 1'b0;
            rf_rd0      <= '0;
            rf_val0     <= '0;
            rf_we1      <= 1'b0;
            rf_rd1      <= '0;
            rf_val1     <= '0;
            st_commit   <= 1'b0;
            st_lsb_id   <= '0;
            bp_valid    <= 1'b0;
            bp_pc       <= '0;
            bp_taken    <= 1'b0;
            bp_correct  <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end
        if (rst) begin
            valid <= '0;
            ready <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                valid <= '0;
                tail  <= head;
                count <= '0;
            end else begin
                for (int k = 0; k < NUM_WB; k++) begin
                    if (wb_valid[k] && valid[wb_id[k*ID_W +: ID_W]]) begin
                        ready[wb_id[k*ID_W +: ID_W]] <= 1'b1;
                        if (kind[wb_id[k*ID_W +: ID_W]] == K_JALR)
                            target[wb_id[k*ID_W +: ID_W]] <= wb_val[k*XLEN +: XLEN];
                        else
                            val[wb_id[k*ID_W +: ID_W]] <= wb_val[k*XLEN +: XLEN];
                    end
                end
                if (dis_fire && !redir) begin
                    valid[tail]    <= 1'b1;
                    ready[tail]    <= dis_done;
                    kind[tail]     <= dis_kind;
                    rd[tail]       <= dis_rd;
                    val[tail]      <= dis_val;
                    target[tail]   <= dis_target;
                    fallthru[tail] <= dis_fallthru;
                    pc[tail]       <= dis_pc;
                    pred[tail]     <= dis_pred;
                    lsb_id[tail]   <= dis_lsb_id;
                    tail           <= tail + ID_W'(1);
                end
                if (c0) begin
                    valid[head] <= 1'b0;
                    head        <= head + ID_W'(1) + ID_W'(c1);
                    if (w0) begin
                        rf_we0  <= 1'b1;
                        rf_rd0  <= rd[head];
                        rf_val0 <= val[head];
                    end
                    if (kind[head] == K_ST) begin
                        st_commit <= 1'b1;
                        st_lsb_id <= lsb_id[head];
                    end
                    if (kind[head] == K_BR) begin
                        bp_valid   <= 1'b1;
                        bp_pc      <= pc[head];
                        bp_taken   <= taken;
                        bp_correct <= pred[head] == taken;
                    end
                    if (redir) begin
                        redirect    <= 1'b1;
                        redirect_pc <= rpc;
                    end
                end
                if (c1) begin
                    valid[h1] <= 1'b0;
                    if (kind[h1] == K_ST) begin
                        st_commit <= 1'b1;
                        st_lsb_id <= lsb_id[h1];
                    end else if (rd[h1] != '0) begin
                        rf_we1  <= 1'b1;
                        rf_rd1  <= rd[h1];
                        rf_val1 <= val[h1];
                    end
                end
                if (redir) begin
                    valid <= '0;
                    tail  <= h1;
                    count <= '0;
                end else begin
                    count <= count + (ID_W+1)'(dis_fire) - (ID_W+1)'(c0) - (ID_W+1)'(c1);
                end
            end
        end
    end
endmodule
